// File: rtl/axis_sa_sched.sv
// rtl/axis_sa_sched.sv - operand sequencer feeding axis_sa from X/K SRAMs
// Issues credit-limited SRAM reads, streams beats through a 2-entry buffer, counts result tiles.
module axis_sa_sched #(
    parameter int Rows   = 4,
    parameter int Cols   = 8,
    parameter int WidthX = 4,
    parameter int WidthK = 8,
    parameter int AddrW  = 10,
    parameter int CntW   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [CntW-1:0]          cfg_depth_i,
    input  logic [CntW-1:0]          cfg_tiles_i,
    input  logic [AddrW-1:0]         cfg_x_base_i,
    input  logic [AddrW-1:0]         cfg_k_base_i,
    input  logic                     cfg_k_reuse_i,
    input  logic                     abort_i,
    output logic                     x_rd_en_o,
    output logic [AddrW-1:0]         x_addr_o,
    input  logic [Rows*WidthX-1:0]   x_rdata_i,
    output logic                     k_rd_en_o,
    output logic [AddrW-1:0]         k_addr_o,
    input  logic [Cols*WidthK-1:0]   k_rdata_i,
    output logic                     sa_s_valid_o,
    input  logic                     sa_s_ready_i,
    output logic                     sa_s_last_o,
    output logic [Rows*WidthX-1:0]   sa_x_data_o,
    output logic [Cols*WidthK-1:0]   sa_k_data_o,
    input  logic                     sa_m_valid_i,
    input  logic                     sa_m_ready_i,
    input  logic                     sa_m_last_i,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int XW = Rows * WidthX;
    localparam int KW = Cols * WidthK;
    localparam int EW = XW + KW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   depth_q, tiles_q, beat_q, tile_q, out_cnt_q, out_cnt_d;
    logic [AddrW-1:0]  x_base_q, k_base_q, tile_off_q;
    logic              reuse_q;
    logic              inflight_q, infl_last_q;
    logic [EW-1:0]     buf_mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        buf_cnt_q;

    logic              rd_en, beat_last, tile_last, s_valid, pop, m_hs, cfg_accept;
    logic              push_mem, pop_mem;
    logic [EW-1:0]     incoming, head;
    logic [AddrW-1:0]  beat_a;

    assign beat_last  = (beat_q == depth_q - CntW'(1));
    assign tile_last  = (tile_q == tiles_q - CntW'(1));
    assign cfg_accept = (state_q == S_IDLE) && cfg_valid_i;
    // The in-flight read counts as buffer occupancy so the buffer can never overflow.
    assign rd_en      = (state_q == S_RUN) && !abort_i &&
                        ((buf_cnt_q + {1'b0, inflight_q}) < 2'd2);

    // Data returning from the SRAM bypasses the buffer when it is empty, giving 1 beat/cycle.
    assign incoming = {infl_last_q, x_rdata_i, k_rdata_i};
    assign head     = (buf_cnt_q != 2'd0) ? buf_mem_q[rd_ptr_q] : incoming;
    assign s_valid  = (buf_cnt_q != 2'd0) || inflight_q;
    assign pop      = s_valid && sa_s_ready_i;
    assign pop_mem  = pop && (buf_cnt_q != 2'd0);
    assign push_mem = inflight_q && !(pop && (buf_cnt_q == 2'd0));
    assign m_hs     = sa_m_valid_i && sa_m_ready_i && sa_m_last_i;

    assign beat_a   = beat_q[AddrW-1:0];
    assign x_addr_o = x_base_q + tile_off_q + beat_a;
    assign k_addr_o = k_base_q + (reuse_q ? beat_a : tile_off_q + beat_a);

    assign sa_s_valid_o = s_valid;
    assign sa_s_last_o  = s_valid && head[EW-1];
    assign sa_x_data_o  = s_valid ? head[EW-2:KW] : '0;
    assign sa_k_data_o  = s_valid ? head[KW-1:0] : '0;

    always_comb begin
        out_cnt_d = out_cnt_q;
        if ((state_q == S_RUN || state_q == S_DRAIN) && m_hs && (out_cnt_q != tiles_q))
            out_cnt_d = out_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cfg_valid_i) state_d = (cfg_tiles_i == '0) ? S_DONE : S_RUN;
                S_RUN:   if (rd_en && beat_last && tile_last) state_d = S_DRAIN;
                S_DRAIN: if ((out_cnt_d == tiles_q) && !s_valid) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        x_rd_en_o   = rd_en;
        k_rd_en_o   = rd_en;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q      <= '0;
            tiles_q      <= '0;
            x_base_q     <= '0;
            k_base_q     <= '0;
            reuse_q      <= 1'b0;
            beat_q       <= '0;
            tile_q       <= '0;
            tile_off_q   <= '0;
            out_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            infl_last_q  <= 1'b0;
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_cnt_q    <= '0;
        end else if (abort_i) begin
            beat_q      <= '0;
            tile_q      <= '0;
            tile_off_q  <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_cnt_q   <= '0;
        end else begin
            inflight_q  <= rd_en;
            infl_last_q <= rd_en && beat_last;
            if (cfg_accept) begin
                depth_q    <= (cfg_depth_i == '0) ? CntW'(1) : cfg_depth_i;
                tiles_q    <= cfg_tiles_i;
                x_base_q   <= cfg_x_base_i;
                k_base_q   <= cfg_k_base_i;
                reuse_q    <= cfg_k_reuse_i;
                beat_q     <= '0;
                tile_q     <= '0;
                tile_off_q <= '0;
                out_cnt_q  <= '0;
            end else begin
                out_cnt_q <= out_cnt_d;
                if (rd_en) begin
                    if (beat_last) begin
                        beat_q     <= '0;
                        tile_q     <= tile_q + CntW'(1);
                        tile_off_q <= tile_off_q + depth_q[AddrW-1:0];
                    end else begin
                        beat_q <= beat_q + CntW'(1);
                    end
                end
            end
            if (push_mem) begin
                buf_mem_q[wr_ptr_q] <= incoming;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop_mem) rd_ptr_q <= ~rd_ptr_q;
            buf_cnt_q <= buf_cnt_q + {1'b0, push_mem} - {1'b0, pop_mem};
        end
    end
endmodule

// File: tb/tb_axis_sa_sched.sv
// tb/tb_axis_sa_sched.sv - directed bench for axis_sa_sched
// SRAM model returns data equal to the read address so beat contents identify their source.
module tb_axis_sa_sched;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_valid, cfg_ready, cfg_reuse, abort;
    logic [15:0] cfg_depth, cfg_tiles;
    logic [9:0]  cfg_x_base, cfg_k_base;
    logic        x_rd_en, k_rd_en;
    logic [9:0]  x_addr, k_addr;
    logic [15:0] x_rdata;
    logic [63:0] k_rdata;
    logic        s_valid, s_ready, s_last;
    logic [15:0] sx_data;
    logic [63:0] sk_data;
    logic        m_valid, m_ready, m_last;
    logic        busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rd_x_q[$];
    int rd_k_q[$];
    logic [15:0] bx_q[$];
    logic [63:0] bk_q[$];
    bit          bl_q[$];
    int outstanding = 0, max_out = 0, stab_err = 0, done_cnt = 0;
    bit stall_prev = 0;
    logic [15:0] prev_x;

    localparam logic [63:0] KTAG = 64'hC0DE_0000_0000_0000;

    axis_sa_sched dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_depth_i(cfg_depth), .cfg_tiles_i(cfg_tiles),
        .cfg_x_base_i(cfg_x_base), .cfg_k_base_i(cfg_k_base), .cfg_k_reuse_i(cfg_reuse),
        .abort_i(abort),
        .x_rd_en_o(x_rd_en), .x_addr_o(x_addr), .x_rdata_i(x_rdata),
        .k_rd_en_o(k_rd_en), .k_addr_o(k_addr), .k_rdata_i(k_rdata),
        .sa_s_valid_o(s_valid), .sa_s_ready_i(s_ready), .sa_s_last_o(s_last),
        .sa_x_data_o(sx_data), .sa_k_data_o(sk_data),
        .sa_m_valid_i(m_valid), .sa_m_ready_i(m_ready), .sa_m_last_i(m_last),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_rd_en) x_rdata <= {6'd0, x_addr};
        if (k_rd_en) k_rdata <= KTAG | {54'd0, k_addr};
    end

    always @(posedge clk) begin
        if (rst_ni) begin
            if (x_rd_en) begin rd_x_q.push_back(int'(x_addr)); rd_k_q.push_back(int'(k_addr)); end
            if (s_valid && s_ready) begin bx_q.push_back(sx_data); bk_q.push_back(sk_data); bl_q.push_back(s_last); end
            if (stall_prev && (!s_valid || sx_data !== prev_x)) stab_err++;
            stall_prev = s_valid && !s_ready;
            prev_x = sx_data;
            outstanding = outstanding + int'(x_rd_en) - int'(s_valid && s_ready);
            if (outstanding > max_out) max_out = outstanding;
            if (done) done_cnt++;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic clear_logs();
        rd_x_q.delete(); rd_k_q.delete(); bx_q.delete(); bk_q.delete(); bl_q.delete();
        outstanding = 0; max_out = 0; stab_err = 0;
    endtask

    task automatic start_job(input int d, input int t, input int xb, input int kb, input bit reuse);
        @(negedge clk);
        cfg_valid = 1; cfg_depth = 16'(d); cfg_tiles = 16'(t);
        cfg_x_base = 10'(xb); cfg_k_base = 10'(kb); cfg_reuse = reuse;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (bx_q.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_result();
        @(negedge clk);
        m_valid = 1; m_ready = 1; m_last = 1;
        @(negedge clk);
        m_valid = 0; m_ready = 0; m_last = 0;
    endtask

    task automatic test_reset();
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); else pass_cnt++;
        total_cnt++; if ({busy, done, s_valid, x_rd_en, k_rd_en, s_last} !== 6'b0)
            $display("FAIL reset_outputs got %b exp 000000", {busy, done, s_valid, x_rd_en, k_rd_en, s_last}); else pass_cnt++;
        total_cnt++; if ({sx_data, sk_data, x_addr, k_addr} !== '0) $display("FAIL reset_data got %h exp 0", {sx_data, sk_data}); else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok;
        clear_logs(); s_ready = 1;
        start_job(4, 2, 0, 0, 0);
        total_cnt++; if (x_rd_en !== 1'b1 || x_addr !== 10'd0) $display("FAIL basic_first_rd got en=%b addr=%0d exp en=1 addr=0", x_rd_en, x_addr); else pass_cnt++;
        total_cnt++; if (s_valid !== 1'b0) $display("FAIL basic_valid_early got %b exp 0", s_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (s_valid !== 1'b1) $display("FAIL basic_first_valid got %b exp 1", s_valid); else pass_cnt++;
        wait_beats(8, ok);
        @(negedge clk);
        total_cnt++; if (!ok || bx_q.size() != 8) $display("FAIL basic_beat_count got %0d exp 8", bx_q.size()); else pass_cnt++;
        for (int i = 0; i < 8 && i < bx_q.size(); i++) begin
            total_cnt++; if (bx_q[i] !== 16'(i) || bl_q[i] !== (i % 4 == 3))
                $display("FAIL basic_beat%0d got x=%0d last=%b exp x=%0d last=%b", i, bx_q[i], bl_q[i], i, (i % 4 == 3)); else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_drain got busy=%b done=%b exp 1 0", busy, done); else pass_cnt++;
        pulse_result();
        total_cnt++; if (done !== 1'b0) $display("FAIL basic_early_done got %b exp 0", done); else pass_cnt++;
        pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL basic_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL basic_idle got done=%b rdy=%b exp 0 1", done, cfg_ready); else pass_cnt++;
    endtask

    task automatic test_reuse();
        bit ok;
        clear_logs(); s_ready = 1;
        start_job(3, 2, 100, 16, 1);
        wait_beats(6, ok);
        total_cnt++; if (!ok || rd_k_q.size() != 6) $display("FAIL reuse_count got %0d exp 6", rd_k_q.size()); else pass_cnt++;
        for (int i = 0; i < 6 && i < rd_k_q.size(); i++) begin
            total_cnt++; if (rd_k_q[i] != 16 + i % 3 || rd_x_q[i] != 100 + i || bk_q[i] !== (KTAG | 64'(16 + i % 3)))
                $display("FAIL reuse_addr%0d got k=%0d x=%0d exp k=%0d x=%0d", i, rd_k_q[i], rd_x_q[i], 16 + i % 3, 100 + i); else pass_cnt++;
        end
        pulse_result(); pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL reuse_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok;
        clear_logs(); s_ready = 1;
        start_job(3, 2, 100, 16, 1);
        wait_beats(1, ok);
        s_ready = 0;
        repeat (5) @(negedge clk);
        total_cnt++; if (x_rd_en !== 1'b0 || s_valid !== 1'b1) $display("FAIL stall_hold got rd_en=%b valid=%b exp 0 1", x_rd_en, s_valid); else pass_cnt++;
        total_cnt++; if (max_out > 2) $display("FAIL stall_credit got %0d exp <=2", max_out); else pass_cnt++;
        s_ready = 1;
        wait_beats(6, ok);
        repeat (3) @(negedge clk);
        total_cnt++; if (!ok || bx_q.size() != 6 || rd_x_q.size() != 6) $display("FAIL stall_count got %0d/%0d exp 6", bx_q.size(), rd_x_q.size()); else pass_cnt++;
        for (int i = 0; i < 6 && i < bx_q.size(); i++) begin
            total_cnt++; if (bx_q[i] !== 16'(100 + i) || bk_q[i] !== (KTAG | 64'(16 + i % 3)) || bl_q[i] !== (i % 3 == 2))
                $display("FAIL stall_beat%0d got x=%0d k=%h exp x=%0d", i, bx_q[i], bk_q[i], 100 + i); else pass_cnt++;
        end
        total_cnt++; if (stab_err != 0) $display("FAIL stall_stable got %0d exp 0", stab_err); else pass_cnt++;
        pulse_result(); pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL stall_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_depth_edges();
        bit ok;
        clear_logs(); s_ready = 1;
        start_job(1, 3, 0, 0, 0);
        wait_beats(3, ok);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (!ok || bx_q[i] !== 16'(i) || bl_q[i] !== 1'b1) $display("FAIL d1_beat%0d got x=%0d last=%b exp x=%0d last=1", i, bx_q[i], bl_q[i], i); else pass_cnt++;
        end
        pulse_result(); pulse_result();
        total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL d1_early got done=%b busy=%b exp 0 1", done, busy); else pass_cnt++;
        pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL d1_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
        clear_logs();
        start_job(0, 2, 50, 0, 0);
        wait_beats(2, ok);
        repeat (2) @(negedge clk);
        total_cnt++; if (!ok || bx_q.size() != 2) $display("FAIL d0_count got %0d exp 2", bx_q.size()); else pass_cnt++;
        for (int i = 0; i < 2 && i < bx_q.size(); i++) begin
            total_cnt++; if (bx_q[i] !== 16'(50 + i) || bl_q[i] !== 1'b1) $display("FAIL d0_beat%0d got x=%0d last=%b exp x=%0d last=1", i, bx_q[i], bl_q[i], 50 + i); else pass_cnt++;
        end
        pulse_result(); pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL d0_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
        clear_logs();
        start_job(4, 0, 0, 0, 0);
        total_cnt++; if (done !== 1'b1 || x_rd_en !== 1'b0) $display("FAIL t0_done got done=%b rd=%b exp 1 0", done, x_rd_en); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0 || rd_x_q.size() != 0) $display("FAIL t0_idle got done=%b busy=%b reads=%0d exp 0 0 0", done, busy, rd_x_q.size()); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit ok;
        int done_base;
        clear_logs(); s_ready = 1;
        start_job(8, 1, 0, 0, 0);
        for (int c = 0; c < 20 && rd_x_q.size() < 3; c++) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        total_cnt++; if (busy !== 1'b0 || s_valid !== 1'b0 || cfg_ready !== 1'b1 || x_rd_en !== 1'b0)
            $display("FAIL abort_idle got busy=%b valid=%b rdy=%b rd=%b exp 0 0 1 0", busy, s_valid, cfg_ready, x_rd_en); else pass_cnt++;
        done_base = done_cnt;
        repeat (4) @(negedge clk);
        total_cnt++; if (done_cnt != done_base || s_valid !== 1'b0) $display("FAIL abort_no_done got %0d exp %0d", done_cnt, done_base); else pass_cnt++;
        clear_logs();
        start_job(2, 1, 200, 300, 0);
        wait_beats(2, ok);
        repeat (2) @(negedge clk);
        total_cnt++; if (!ok || bx_q.size() != 2) $display("FAIL abort_new_count got %0d exp 2", bx_q.size()); else pass_cnt++;
        for (int i = 0; i < 2 && i < bx_q.size(); i++) begin
            total_cnt++; if (bx_q[i] !== 16'(200 + i) || bk_q[i] !== (KTAG | 64'(300 + i)) || bl_q[i] !== (i == 1))
                $display("FAIL abort_new_beat%0d got x=%0d last=%b exp x=%0d", i, bx_q[i], bl_q[i], 200 + i); else pass_cnt++;
        end
        pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL abort_new_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_cfg_ignore_and_reset();
        bit ok;
        clear_logs(); s_ready = 0;
        start_job(4, 1, 64, 0, 0);
        @(negedge clk);
        cfg_valid = 1; cfg_depth = 2; cfg_x_base = 500;
        #1;
        total_cnt++; if (cfg_ready !== 1'b0 || busy !== 1'b1) $display("FAIL cfg_busy got rdy=%b busy=%b exp 0 1", cfg_ready, busy); else pass_cnt++;
        @(negedge clk);
        cfg_valid = 0; s_ready = 1;
        wait_beats(4, ok);
        repeat (3) @(negedge clk);
        total_cnt++; if (!ok || bx_q.size() != 4) $display("FAIL cfg_count got %0d exp 4", bx_q.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < bx_q.size(); i++) begin
            total_cnt++; if (bx_q[i] !== 16'(64 + i)) $display("FAIL cfg_beat%0d got %0d exp %0d", i, bx_q[i], 64 + i); else pass_cnt++;
        end
        pulse_result();
        total_cnt++; if (done !== 1'b1) $display("FAIL cfg_done got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
        clear_logs();
        start_job(8, 2, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_ni = 0;
        #1;
        total_cnt++; if ({busy, s_valid, x_rd_en, s_last, done} !== 5'b0 || cfg_ready !== 1'b1)
            $display("FAIL async_reset got %b rdy=%b exp 00000 1", {busy, s_valid, x_rd_en, s_last, done}, cfg_ready); else pass_cnt++;
        @(negedge clk);
        rst_ni = 1;
    endtask

    initial begin
        rst_ni = 0; cfg_valid = 0; cfg_depth = 0; cfg_tiles = 0; cfg_x_base = 0; cfg_k_base = 0;
        cfg_reuse = 0; abort = 0; s_ready = 0; m_valid = 0; m_ready = 0; m_last = 0;
        x_rdata = 16'h1234; k_rdata = 64'h5555;
        repeat (3) @(negedge clk);
        test_reset();
        rst_ni = 1;
        @(negedge clk);
        test_basic();
        test_reuse();
        test_stall();
        test_depth_edges();
        test_abort();
        test_cfg_ignore_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
